// File: rtl/fp_addsub_pipe.sv
// Three-stage floating-point add/sub (align, add, normalise/round/pack) for {sign, exp, fract}
// words with hidden 1, exp==0 meaning zero, RNE rounding, saturating overflow and flush-to-zero.
module fp_addsub_pipe #(
  parameter  int EXP_W  = 4,
  parameter  int FRAC_W = 4,
  localparam int W      = 1 + EXP_W + FRAC_W
) (
  input  logic         clk50M,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         op_sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sumF,
  output logic         overflow,
  output logic         underflow,
  output logic         zero
);

  localparam int STAGES = 3;
  localparam int MW     = FRAC_W + 4;   // hidden, fract, guard, round, sticky
  localparam int LZW    = $clog2(MW);
  localparam int EW     = ((EXP_W > LZW) ? EXP_W : LZW) + 2;
  localparam logic signed [EW-1:0] E_MAX = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] E_ONE = EW'(1);

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic             eff_sub;
    logic [MW-1:0]    big_m;
    logic [MW-1:0]    sml_m;
  } s1_t;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MW:0]      sum;
  } s2_t;

  logic [STAGES:1] vld_pipe;
  logic [STAGES:1] ld;
  s1_t s1_d, s1_q;
  s2_t s2_d, s2_q;

  // Backpressure: a stage loads when the stage after it is empty or draining.
  always_comb begin
    ld[3] = ~vld_pipe[3] | out_ready;
    ld[2] = ~vld_pipe[2] | ld[3];
    ld[1] = ~vld_pipe[1] | ld[2];
  end

  assign in_ready  = ld[1];
  assign out_valid = vld_pipe[3];

  // ---------------- S1: align ----------------
  logic              a_s, b_s, b_eff, a_big;
  logic [EXP_W-1:0]  a_e, b_e, big_e, sml_e, d;
  logic [FRAC_W-1:0] a_f, b_f, big_f, sml_f;
  logic [MW-1:0]     sml_full, sml_shr, lost_mask;

  assign {a_s, a_e, a_f} = A;
  assign {b_s, b_e, b_f} = B;
  assign b_eff = b_s ^ op_sub;
  assign a_big = {a_e, a_f} >= {b_e, b_f};

  always_comb begin
    big_e     = a_big ? a_e : b_e;
    big_f     = a_big ? a_f : b_f;
    sml_e     = a_big ? b_e : a_e;
    sml_f     = a_big ? b_f : a_f;
    d         = big_e - sml_e;
    sml_full  = (sml_e == '0) ? '0 : {1'b1, sml_f, 3'b000};
    sml_shr   = sml_full >> d;
    lost_mask = ~({MW{1'b1}} << d);
    s1_d.sign    = a_big ? a_s : b_eff;
    s1_d.exp     = big_e;
    s1_d.eff_sub = a_s ^ b_eff;
    s1_d.big_m   = (big_e == '0) ? '0 : {1'b1, big_f, 3'b000};
    // Everything shifted past the sticky position still counts toward sticky.
    s1_d.sml_m   = {sml_shr[MW-1:1], sml_shr[0] | (|(sml_full & lost_mask))};
  end

  // ---------------- S2: add ----------------
  always_comb begin
    s2_d.sign = s1_q.sign;
    s2_d.exp  = s1_q.exp;
    s2_d.sum  = s1_q.eff_sub ? ({1'b0, s1_q.big_m} - {1'b0, s1_q.sml_m})
                             : ({1'b0, s1_q.big_m} + {1'b0, s1_q.sml_m});
  end

  // ---------------- S3: normalise, round, pack ----------------
  logic                    carry, up;
  logic [EW-1:0]           lz, exp_x;
  logic [MW-1:0]           norm;
  logic [FRAC_W+1:0]       mant;
  logic [FRAC_W-1:0]       fract;
  logic signed [EW-1:0]    e_n, e_r;
  logic [W-1:0]            res_w;
  logic                    res_o, res_u, res_z;

  always_comb begin
    carry = s2_q.sum[MW];
    lz    = '0;
    for (int i = 0; i < MW; i++)
      if (s2_q.sum[i]) lz = EW'(MW - 1 - i);
    exp_x = {{(EW-EXP_W){1'b0}}, s2_q.exp};
    if (carry) begin
      norm = {s2_q.sum[MW:2], s2_q.sum[1] | s2_q.sum[0]};
      e_n  = exp_x + EW'(1);
    end else begin
      norm = s2_q.sum[MW-1:0] << lz;
      e_n  = exp_x - lz;
    end
    up    = norm[2] & (norm[1] | norm[0] | norm[3]);
    mant  = {1'b0, norm[MW-1:3]} + {{(FRAC_W+1){1'b0}}, up};
    e_r   = e_n + EW'(mant[FRAC_W+1]);
    fract = mant[FRAC_W+1] ? mant[FRAC_W:1] : mant[FRAC_W-1:0];

    res_w = {s2_q.sign, e_r[EXP_W-1:0], fract};
    res_o = 1'b0;
    res_u = 1'b0;
    res_z = 1'b0;
    if (s2_q.sum == '0) begin
      res_w = '0;
      res_z = 1'b1;
    end else if (e_r > E_MAX) begin
      res_w = {s2_q.sign, {EXP_W{1'b1}}, {FRAC_W{1'b1}}};
      res_o = 1'b1;
    end else if (e_r < E_ONE) begin
      res_w = '0;
      res_u = 1'b1;
      res_z = 1'b1;
    end
  end

  // ---------------- pipeline registers ----------------
  always_ff @(posedge clk50M or negedge rst) begin
    if (!rst) begin
      vld_pipe  <= '0;
      s1_q      <= '0;
      s2_q      <= '0;
      sumF      <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      zero      <= 1'b0;
    end else begin
      if (ld[1]) begin
        vld_pipe[1] <= in_valid;
        if (in_valid) s1_q <= s1_d;
      end
      if (ld[2]) begin
        vld_pipe[2] <= vld_pipe[1];
        if (vld_pipe[1]) s2_q <= s2_d;
      end
      if (ld[3]) begin
        vld_pipe[3] <= vld_pipe[2];
        if (vld_pipe[2]) begin
          sumF      <= res_w;
          overflow  <= res_o;
          underflow <= res_u;
          zero      <= res_z;
        end
      end
    end
  end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Bench for fp_addsub_pipe: exact-integer reference model, scoreboard compared every output cycle,
// directed literal cases, backpressure, reset flush and randomized traffic.
module tb_fp_addsub_pipe;
  localparam int EXP_W  = 4;
  localparam int FRAC_W = 4;
  localparam int W      = 1 + EXP_W + FRAC_W;

  typedef struct packed {
    logic [W-1:0] f;
    logic         ovf;
    logic         unf;
    logic         zr;
  } res_t;

  logic         clk50M = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         op_sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sumF;
  logic         overflow, underflow, zero;

  res_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   n_acc = 0;
  int   n_pop = 0;

  fp_addsub_pipe #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) dut (
    .clk50M(clk50M), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .op_sub(op_sub), .out_valid(out_valid), .out_ready(out_ready),
    .sumF(sumF), .overflow(overflow), .underflow(underflow), .zero(zero)
  );

  always #10 clk50M = ~clk50M;

  // Reference: operands become exact signed integers ({1,fract} << exp), summed exactly,
  // then rounded to FRAC_W+1 significant bits with ties to even.
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic op);
    longint va, vb, s, mag, mant, rem, half, one;
    int     p, e;
    logic   sg;
    res_t   r;
    one = 1;
    r   = '0;
    va  = (a[W-2:FRAC_W] == '0) ? 0 : (longint'({1'b1, a[FRAC_W-1:0]}) << a[W-2:FRAC_W]);
    vb  = (b[W-2:FRAC_W] == '0) ? 0 : (longint'({1'b1, b[FRAC_W-1:0]}) << b[W-2:FRAC_W]);
    if (a[W-1]) va = -va;
    if (b[W-1] ^ op) vb = -vb;
    s = va + vb;
    if (s == 0) begin
      r.zr = 1'b1;
      return r;
    end
    sg  = (s < 0);
    mag = sg ? -s : s;
    p   = 0;
    for (int i = 0; i < 63; i++) if (mag[i]) p = i;
    e = p - FRAC_W;
    if (e > 0) begin
      mant = mag >> e;
      rem  = mag & ((one << e) - 1);
      half = one << (e - 1);
      if (rem > half || (rem == half && mant[0])) mant++;
    end else begin
      mant = mag << (-e);
    end
    if (mant == (one << (FRAC_W + 1))) begin
      mant = mant >> 1;
      e++;
    end
    if (e > (1 << EXP_W) - 1) begin
      r.f   = {sg, {EXP_W{1'b1}}, {FRAC_W{1'b1}}};
      r.ovf = 1'b1;
    end else if (e < 1) begin
      r.unf = 1'b1;
      r.zr  = 1'b1;
    end else begin
      r.f = {sg, EXP_W'(e), FRAC_W'(mant)};
    end
    return r;
  endfunction

  task automatic check(input string name, input longint got, input longint want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // Scoreboard: every cycle out_valid is high the output must equal the oldest outstanding item.
  task automatic monitor();
    res_t got;
    forever begin
      @(negedge clk50M);
      if (!rst) begin
        exp_q.delete();
      end else begin
        if (out_valid) begin
          got = {sumF, overflow, underflow, zero};
          vectors++;
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_output: got %h with no item outstanding", got);
          end else begin
            if (got !== exp_q[0]) begin
              miscompares++;
              $display("FAIL result: got %h expected %h", got, exp_q[0]);
            end
            if (out_ready) begin
              void'(exp_q.pop_front());
              n_pop++;
            end
          end
        end
        if (in_valid && in_ready) begin
          exp_q.push_back(model(A, B, op_sub));
          n_acc++;
        end
      end
    end
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic op);
    bit acc;
    int n;
    A = a; B = b; op_sub = op; in_valid = 1'b1;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 200) begin
      @(negedge clk50M);
      acc = in_ready;
      @(posedge clk50M);
      #1;
      n++;
    end
    in_valid = 1'b0;
    check("send_accept", acc, 1);
  endtask

  task automatic directed(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic op, input res_t want);
    int lat;
    check({name, "_model"}, model(a, b, op), want);
    send(a, b, op);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk50M);
      #1;
      lat++;
    end
    check({name, "_latency"}, lat, 3);
    check({name, "_out"}, {sumF, overflow, underflow, zero}, want);
    @(posedge clk50M);
    #1;
  endtask

  function automatic logic [W-1:0] rnd_word();
    logic [EXP_W-1:0] e;
    e = ($urandom_range(0, 7) == 0) ? '0 : EXP_W'($urandom_range(1, (1 << EXP_W) - 1));
    return {1'($urandom), e, FRAC_W'($urandom)};
  endfunction

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || out_valid) && n < 500) begin
      @(posedge clk50M);
      #1;
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    logic [W-1:0] a, b;
    int base_acc, base_pop;
    fork
      monitor();
    join_none

    repeat (2) @(posedge clk50M);
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_sumF", sumF, 0);
    check("reset_flags", {overflow, underflow, zero}, 0);
    rst = 1'b1;
    #1;
    check("reset_in_ready", in_ready, 1);
    @(posedge clk50M);
    #1;

    directed("add",        9'b0_0011_1000, 9'b0_0011_1000, 1'b0, {9'b0_0100_1000, 3'b000});
    directed("cancel",     9'b0_0101_0000, 9'b0_0101_0000, 1'b1, {9'b0_0000_0000, 3'b001});
    directed("rne_even",   9'b0_0100_0000, 9'b0_0011_0001, 1'b0, {9'b0_0100_1000, 3'b000});
    directed("rne_up",     9'b0_0100_0000, 9'b0_0011_0011, 1'b0, {9'b0_0100_1010, 3'b000});
    directed("overflow",   9'b0_1111_1000, 9'b0_1111_1000, 1'b0, {9'b0_1111_1111, 3'b100});
    directed("underflow",  9'b0_0001_0001, 9'b0_0001_0000, 1'b1, {9'b0_0000_0000, 3'b011});
    directed("zero_minus", 9'b0_0000_1111, 9'b0_0010_0101, 1'b1, {9'b1_0010_0101, 3'b000});
    directed("zero_zero",  9'b1_0000_0011, 9'b0_0000_0000, 1'b0, {9'b0_0000_0000, 3'b001});

    // Backpressure: five back-to-back items into a stalled pipe.
    out_ready = 1'b0;
    base_acc = n_acc;
    base_pop = n_pop;
    fork
      begin
        for (int i = 0; i < 5; i++) send(rnd_word(), rnd_word(), 1'($urandom));
      end
      begin
        repeat (8) @(posedge clk50M);
        #1;
        check("bp_accepted", n_acc - base_acc, 3);
        check("bp_in_ready", in_ready, 0);
        check("bp_out_valid", out_valid, 1);
        out_ready = 1'b1;
      end
    join
    drain();
    check("bp_delivered", n_pop - base_pop, 5);

    // Reset with items in flight.
    out_ready = 1'b0;
    send(9'b0_0011_1000, 9'b0_0011_1000, 1'b0);
    send(9'b0_0100_0000, 9'b0_0011_0011, 1'b0);
    @(posedge clk50M);
    #1;
    check("pre_reset_out_valid", out_valid, 1);
    #3 rst = 1'b0;
    #1;
    check("async_reset_out_valid", out_valid, 0);
    check("async_reset_sumF", sumF, 0);
    repeat (2) @(negedge clk50M);
    #2 rst = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk50M);
      #1;
      check("post_reset_no_stale", out_valid, 0);
    end
    directed("post_reset", 9'b0_0011_1000, 9'b0_0011_1000, 1'b0, {9'b0_0100_1000, 3'b000});

    // Randomized traffic with random stalls, biased toward cancellation and large exponents.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk50M);
      #1;
      a = rnd_word();
      b = rnd_word();
      case ($urandom_range(0, 3))
        0: b = {1'($urandom), a[W-2:FRAC_W], FRAC_W'($urandom)};
        1: begin
          a[W-2:FRAC_W] = EXP_W'((1 << EXP_W) - 1 - $urandom_range(0, 1));
          b[W-2:FRAC_W] = EXP_W'((1 << EXP_W) - 1 - $urandom_range(0, 1));
        end
        default: ;
      endcase
      A = a;
      B = b;
      op_sub = 1'($urandom);
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk50M);
    #1;
    in_valid = 1'b0;
    drain();
    check("final_idle", out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
